// File: rtl/tnoc_vc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tnoc_vc_input_buffer: per-VC credit-returning input FIFOs for a tnoc     |
// | router port. Optional framing check: TNOC_VC_INPUT_BUFFER_FRAMING_CHECK_EN|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tnoc_vc_input_buffer #(
  parameter int FLIT_WIDTH = 64,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 4,
  parameter int VC_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear,
  input  logic                           i_flit_valid,
  input  logic [VC_WIDTH-1:0]            i_flit_vc,
  input  logic                           i_flit_head,
  input  logic                           i_flit_tail,
  input  logic [FLIT_WIDTH-1:0]          i_flit_data,
  output logic [2*CHANNELS-1:0]          o_credit_return,
  output logic [CHANNELS-1:0]            o_flit_valid,
  input  logic [CHANNELS-1:0]            i_flit_ready,
  output logic [CHANNELS-1:0]            o_flit_head,
  output logic [CHANNELS-1:0]            o_flit_tail,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit_data,
  output logic [CHANNELS-1:0]            o_empty,
  output logic [CHANNELS-1:0]            o_full,
  output logic [CHANNELS-1:0]            o_overflow,
  output logic [CHANNELS-1:0]            o_framing_error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = FLIT_WIDTH + 2;

`ifdef TNOC_VC_INPUT_BUFFER_FRAMING_CHECK_EN
  typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [1:0]       credit_q;
    logic             ovf_q;
    logic             w_sel;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_store;
    logic             w_fdrop;
    logic [ENT_W-1:0] w_head_ent;

    assign w_sel   = i_flit_valid && (i_flit_vc == VC_WIDTH'(c));
    assign w_empty = (wr_q == rd_q);
    // Same index with differing wrap bits means the FIFO has lapped itself.
    assign w_full  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                     (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign w_pop   = !w_empty && i_flit_ready[c];

`ifdef TNOC_VC_INPUT_BUFFER_FRAMING_CHECK_EN
    state_t state_q;
    logic   err_q;
    logic   w_accept;

    // An overflowed flit never reaches the framing FSM.
    assign w_accept = w_sel && !w_full;
    assign w_fdrop  = w_accept && (state_q == S_IDLE) && !i_flit_head;
    assign w_store  = w_accept && !w_fdrop;

    always_ff @(posedge clk) begin
      if (rst || i_clear) begin
        state_q <= S_IDLE;
        err_q   <= 1'b0;
      end else if (w_accept) begin
        if (w_fdrop || ((state_q == S_IN_PKT) && i_flit_head)) err_q <= 1'b1;
        if (w_store) state_q <= i_flit_tail ? S_IDLE : S_IN_PKT;
      end
    end

    assign o_framing_error[c] = err_q;
`else
    assign w_fdrop            = 1'b0;
    assign w_store            = w_sel && !w_full;
    assign o_framing_error[c] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst || i_clear) begin
        wr_q     <= '0;
        rd_q     <= '0;
        credit_q <= 2'd0;
        ovf_q    <= 1'b0;
      end else begin
        if (w_store) wr_q <= wr_q + PTR_W'(1);
        if (w_pop) rd_q <= rd_q + PTR_W'(1);
        credit_q <= {1'b0, w_pop} + {1'b0, w_fdrop};
        if (w_sel && w_full) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_store) mem_q[wr_q[IDX_W-1:0]] <= {i_flit_head, i_flit_tail, i_flit_data};
    end

    assign w_head_ent = mem_q[rd_q[IDX_W-1:0]];

    assign o_flit_valid[c]                       = !w_empty;
    assign o_flit_head[c]                        = w_head_ent[ENT_W-1];
    assign o_flit_tail[c]                        = w_head_ent[ENT_W-2];
    assign o_flit_data[c*FLIT_WIDTH +: FLIT_WIDTH] = w_head_ent[FLIT_WIDTH-1:0];
    assign o_credit_return[2*c +: 2]             = credit_q;
    assign o_empty[c]                            = w_empty;
    assign o_full[c]                             = w_full;
    assign o_overflow[c]                         = ovf_q;
  end

endmodule
`default_nettype wire
